// File: rtl/cand_sen_ctrl_if.sv
// Bundle of the request/enable handshake around the clock-gate sequencer.
//   REQ     : gated-clock request from fabric logic (asynchronous, level)
//   TEST_EN : test override, synchronous to CLK, forces SEN high
//   SEN     : enable into the clock-AND gate cell (falling-edge launched)
//   ACK     : gated clock is live (FSM in ON)
//   BUSY    : sequencer is not idle
// master drives the request side; slave is the sequencer itself.
`timescale 1ns/1ps
interface cand_sen_ctrl_if;
   logic REQ;
   logic TEST_EN;
   logic SEN;
   logic ACK;
   logic BUSY;

   modport master (output REQ, output TEST_EN, input SEN, input ACK, input BUSY);
   modport slave  (input REQ, input TEST_EN, output SEN, output ACK, output BUSY);
endinterface

// File: rtl/cand_sen_ctrl.sv
// Enable sequencer feeding the select input of a clock-AND gate cell.
// Synchronizes an asynchronous on/off request, walks OFF -> WAKE -> ON ->
// DRAIN -> OFF with programmable dwell times, and launches SEN from a
// falling-edge flop so the gate input only moves while CLK is low.
// Ports:
//   CLK : free-running clock, same net as the gate cell CLKIN
//   RST : asynchronous active-high reset
//   csc : cand_sen_ctrl_if.slave (REQ, TEST_EN in; SEN, ACK, BUSY out)
`timescale 1ns/1ps
module cand_sen_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ON_DLY      = 4,
   parameter int unsigned MIN_ON      = 8,
   parameter int unsigned OFF_DLY     = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             CLK,
   input  logic             RST,
   cand_sen_ctrl_if.slave   csc
);

   // Largest dwell value the shared counter can hold.
   localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_WAKE  = 2'd1;
   localparam logic [1:0] ST_ON    = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   // Counter reload values: a dwell of N cycles counts N-1 down to 0.
   localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(ON_DLY - 1);
   localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(MIN_ON - 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(OFF_DLY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   // Elaboration-time parameter range checks.
   if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
      $error("cand_sen_ctrl: CNT_W must be 1..31");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("cand_sen_ctrl: SYNC_STAGES must be 2..3");
   end
   if (ON_DLY < 1 || ON_DLY > CNT_MAX) begin : g_bad_on_dly
      $error("cand_sen_ctrl: ON_DLY out of range for CNT_W");
   end
   if (MIN_ON < 1 || MIN_ON > CNT_MAX) begin : g_bad_min_on
      $error("cand_sen_ctrl: MIN_ON out of range for CNT_W");
   end
   if (OFF_DLY < 1 || OFF_DLY > CNT_MAX) begin : g_bad_off_dly
      $error("cand_sen_ctrl: OFF_DLY out of range for CNT_W");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;
   logic [1:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ack_q, ack_d;
   logic                   busy_q, busy_d;
   logic                   test_en_q;
   logic                   sen_nxt;
   logic                   sen_q;

   // REQ synchronizer; req_s is the last stage.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], csc.REQ};
      end
   end

   assign req_s = sync_q[SYNC_STAGES-1];

   // State, counter and rising-edge outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_OFF;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         test_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         test_en_q <= csc.TEST_EN;
      end
   end

   // Next-state logic; sen_nxt reflects the current (registered) state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sen_nxt = 1'b0;

      case (state_q)
         ST_OFF: begin
            if (req_s) begin
               state_d = ST_WAKE;
               cnt_d   = WAKE_LOAD;
            end
         end

         ST_WAKE: begin
            if (!req_s) begin
               state_d = ST_OFF;
            end else if (cnt_q == '0) begin
               state_d = ST_ON;
               cnt_d   = ON_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         ST_ON: begin
            sen_nxt = 1'b1;
            // An early drop is simply re-evaluated each cycle until the
            // minimum-on count has expired, so it is deferred, never lost.
            if (cnt_q == '0) begin
               if (!req_s) begin
                  state_d = ST_DRAIN;
                  cnt_d   = DRAIN_LOAD;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         ST_DRAIN: begin
            sen_nxt = 1'b1;
            if (req_s) begin
               state_d = ST_ON;
               cnt_d   = ON_LOAD;
            end else if (cnt_q == '0) begin
               state_d = ST_OFF;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
         end
      endcase

      ack_d  = (state_d == ST_ON);
      busy_d = (state_d != ST_OFF);
   end

   // Falling-edge launch keeps SEN stable while CLK is high at the AND gate.
   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         sen_q <= 1'b0;
      end else begin
         sen_q <= sen_nxt | test_en_q;
      end
   end

   assign csc.SEN  = sen_q;
   assign csc.ACK  = ack_q;
   assign csc.BUSY = busy_q;

endmodule

// File: tb/tb_cand_sen_ctrl.sv
`timescale 1ns/1ps
module tb_cand_sen_ctrl;

   logic CLK     = 1'b0;
   logic RST     = 1'b1;
   logic clk_run = 1'b1;

   int n_chk = 0;
   int n_bad = 0;

   cand_sen_ctrl_if csc ();

   cand_sen_ctrl dut (
      .CLK (CLK),
      .RST (RST),
      .csc (csc.slave)
   );

   always begin
      #5;
      if (clk_run) CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [32:0] win(input int lo, input int hi);
      logic [32:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   // SEN may only move while CLK is low, reset excepted.
   always @(csc.SEN) begin
      if (!RST) chk("sen_chg_clk_low", 32'(CLK), 32'd0);
   end

   // Bit n of each vector: REQ/TEST_EN sampled at rising edge n, and the
   // expected ACK/BUSY after rising edge n and SEN after falling edge n.
   task automatic run_scn(input string name, input logic [32:0] req, input logic [32:0] ten,
                          input logic [32:0] e_ack, input logic [32:0] e_busy,
                          input logic [32:0] e_sen);
      csc.REQ     = req[1];
      csc.TEST_EN = ten[1];
      for (int n = 1; n <= 32; n++) begin
         @(posedge CLK); #1;
         chk($sformatf("%s ack@%0d", name, n), 32'(csc.ACK), 32'(e_ack[n]));
         chk($sformatf("%s busy@%0d", name, n), 32'(csc.BUSY), 32'(e_busy[n]));
         @(negedge CLK); #1;
         chk($sformatf("%s sen@%0d", name, n), 32'(csc.SEN), 32'(e_sen[n]));
         if (n < 32) begin
            csc.REQ     = req[n+1];
            csc.TEST_EN = ten[n+1];
         end
      end
      csc.REQ     = 1'b0;
      csc.TEST_EN = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
   endtask

   initial begin
      csc.REQ     = 1'b0;
      csc.TEST_EN = 1'b0;
      #2;
      chk("rst sen", 32'(csc.SEN), 32'd0);
      chk("rst ack", 32'(csc.ACK), 32'd0);
      chk("rst busy", 32'(csc.BUSY), 32'd0);
      repeat (3) @(negedge CLK);
      #1 RST = 1'b0;
      repeat (3) @(posedge CLK);
      #1;

      run_scn("basic", win(1, 19), '0, win(7, 21), win(3, 23), win(7, 23));
      run_scn("abort", win(1, 3), '0, '0, win(3, 5), '0);
      run_scn("minon", win(1, 7), '0, win(7, 14), win(3, 16), win(7, 16));
      run_scn("rereq", win(1, 12) | win(14, 19), '0,
              win(7, 14) | win(16, 23), win(3, 25), win(7, 25));
      run_scn("test_off", '0, win(1, 3), '0, '0, win(1, 3));
      run_scn("test_fsm", win(1, 19), win(1, 30), win(7, 21), win(3, 23), win(1, 30));

      // Asynchronous reset from ON with the clock frozen low.
      csc.REQ = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      chk("pre_rst ack", 32'(csc.ACK), 32'd1);
      chk("pre_rst busy", 32'(csc.BUSY), 32'd1);
      @(negedge CLK); #1;
      chk("pre_rst sen", 32'(csc.SEN), 32'd1);
      clk_run = 1'b0;
      #20;
      RST = 1'b1;
      #1;
      chk("async_rst sen", 32'(csc.SEN), 32'd0);
      chk("async_rst ack", 32'(csc.ACK), 32'd0);
      chk("async_rst busy", 32'(csc.BUSY), 32'd0);
      csc.REQ = 1'b0;
      #5 RST = 1'b0;
      #1 clk_run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         chk($sformatf("post_rst busy%0d", i), 32'(csc.BUSY), 32'd0);
         chk($sformatf("post_rst ack%0d", i), 32'(csc.ACK), 32'd0);
         @(negedge CLK); #1;
         chk($sformatf("post_rst sen%0d", i), 32'(csc.SEN), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
